// File: rtl/simple_bus_mem_arb.sv
// simple_bus_mem_arb: round-robin multi-master arbiter in front of a wait-stated local memory
module simple_bus_mem_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [2*NUM_MASTERS-1:0]      mode,
    input  logic [ADDR_W*NUM_MASTERS-1:0] addr,
    input  logic [DATA_W*NUM_MASTERS-1:0] wdata,
    output logic [NUM_MASTERS-1:0]        gnt,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rdy
);
    localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           last, last_nxt, cur, cur_nxt, win;
    logic                    found;
    int                      j;
    logic [1:0]              op, op_nxt;
    logic [ADDR_W-1:0]       a, a_nxt;
    logic [DATA_W-1:0]       d, d_nxt, rdata_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [NUM_MASTERS-1:0]  gnt_nxt;
    logic                    rdy_nxt, commit;
    logic [DATA_W-1:0]       mem [2**ADDR_W];

    // first requester after the last granted master, wrapping around
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = (int'(last) + i) % NUM_MASTERS;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    // next state, latched command and output values
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cur_nxt   = cur;
        op_nxt    = op;
        a_nxt     = a;
        d_nxt     = d;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        rdy_nxt   = 1'b0;
        rdata_nxt = '0;
        commit    = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_nxt = ACCESS;
                cur_nxt   = win;
                gnt_nxt   = NUM_MASTERS'(1) << win;
                op_nxt    = mode[2*win +: 2];
                a_nxt     = addr[ADDR_W*win +: ADDR_W];
                d_nxt     = wdata[DATA_W*win +: DATA_W];
                cnt_nxt   = 4'(WAIT_CYCLES);
            end
            ACCESS: if (cnt != 4'd0) begin
                cnt_nxt = cnt - 4'd1;
            end else begin
                state_nxt = DONE;
                rdy_nxt   = 1'b1;
                rdata_nxt = op[0] ? mem[a] : '0;
                commit    = op[1];
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                last_nxt  = cur;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= IW'(NUM_MASTERS - 1);
            cur   <= '0;
            op    <= '0;
            a     <= '0;
            d     <= '0;
            cnt   <= '0;
            gnt   <= '0;
            rdy   <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cur   <= cur_nxt;
            op    <= op_nxt;
            a     <= a_nxt;
            d     <= d_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            rdy   <= rdy_nxt;
            rdata <= rdata_nxt;
        end
    end

    // storage keeps its contents across reset; a write racing reset is dropped
    always_ff @(posedge clk) begin
        if (commit && !rst) mem[a] <= d;
    end
endmodule

// File: tb/tb_simple_bus_mem_arb.sv
// tb_simple_bus_mem_arb: scoreboard bench driving a 1-wait and a 4-wait instance in lockstep
module tb_simple_bus_mem_arb;
    typedef struct {int m; logic [7:0] d;} exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req4;
    logic [3:0]  mode;
    logic [15:0] addr, wdata;
    logic [1:0]  gnt, gnt4;
    logic [7:0]  rdata, rdata4;
    logic        rdy, rdy4;
    logic [7:0]  model [256];
    exp_t        qa[$], qb[$];
    int          n_cmp = 0, n_bad = 0;

    simple_bus_mem_arb #(.NUM_MASTERS(2), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rdata(rdata), .rdy(rdy)
    );

    simple_bus_mem_arb #(.NUM_MASTERS(2), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(4)) u_b (
        .clk(clk), .rst(rst), .req(req4), .mode(mode), .addr(addr), .wdata(wdata),
        .gnt(gnt4), .rdata(rdata4), .rdy(rdy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every completion is matched against the oldest expected result
    always @(negedge clk) begin
        exp_t ea, eb;
        if (rdy) begin
            if (qa.size() == 0) check("a_extra_rdy", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_rdata", rdata, ea.d);
                check("a_gnt_at_rdy", gnt, 1 << ea.m);
            end
        end
        if (rdy4) begin
            if (qb.size() == 0) check("b_extra_rdy", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_rdata", rdata4, eb.d);
                check("b_gnt_at_rdy", gnt4, 1 << eb.m);
            end
        end
    end

    task automatic run(input int m, input logic [1:0] md, input logic [7:0] ad,
                       input logic [7:0] wd, input bit mess);
        exp_t e;
        int la, lb;
        e.m = m;
        e.d = md[0] ? model[ad] : 8'h00;
        if (md[1]) model[ad] = wd;
        qa.push_back(e);
        qb.push_back(e);
        mode[2*m +: 2]  = md;
        addr[8*m +: 8]  = ad;
        wdata[8*m +: 8] = wd;
        req[m]  = 1'b1;
        req4[m] = 1'b1;
        la = 0;
        lb = 0;
        for (int n = 1; n <= 20 && (la == 0 || lb == 0); n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                check("a_gnt", gnt, 1 << m);
                check("b_gnt", gnt4, 1 << m);
                if (mess) begin
                    mode[2*m +: 2]  = ~md;
                    addr[8*m +: 8]  = ~ad;
                    wdata[8*m +: 8] = ~wd;
                    req[m]  = 1'b0;
                    req4[m] = 1'b0;
                end
            end
            if (rdy && la == 0) begin
                la = n;
                req[m] = 1'b0;
            end
            if (rdy4 && lb == 0) begin
                lb = n;
                req4[m] = 1'b0;
            end
        end
        req  = '0;
        req4 = '0;
        check("a_latency", la, 3);
        check("b_latency", lb, 6);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen, grants;
        logic [1:0] pg;
        rst = 1'b1; req = '0; req4 = '0; mode = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_a", gnt, 0);
        check("rst_rdy_a", rdy, 0);
        check("rst_rdata_a", rdata, 0);
        check("rst_gnt_b", gnt4, 0);
        check("rst_rdy_b", rdy4, 0);
        check("rst_rdata_b", rdata4, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        run(0, 2'b10, 8'h10, 8'hA5, 1'b0);
        run(0, 2'b01, 8'h10, 8'h00, 1'b0);
        run(1, 2'b10, 8'h20, 8'h3C, 1'b0);
        run(1, 2'b11, 8'h20, 8'hC3, 1'b0);
        run(0, 2'b01, 8'h20, 8'h00, 1'b0);
        run(1, 2'b01, 8'h10, 8'h5A, 1'b1);
        run(0, 2'b10, 8'h30, 8'h11, 1'b0);
        run(1, 2'b00, 8'h30, 8'h99, 1'b1);

        // write in flight, reset lands on the edge that would complete it
        mode[1:0] = 2'b10; addr[7:0] = 8'h30; wdata[7:0] = 8'h55;
        req = 2'b01; req4 = 2'b01;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1; req = '0; req4 = '0;
        @(posedge clk);
        @(negedge clk);
        check("abort_rdy_a", rdy, 0);
        check("abort_gnt_a", gnt, 0);
        check("abort_rdata_a", rdata, 0);
        check("abort_rdy_b", rdy4, 0);
        check("abort_gnt_b", gnt4, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // both masters request continuously on the 1-wait instance
        mode = 4'b0101;
        addr = {8'h20, 8'h10};
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.m = k % 2;
            e.d = (k % 2 == 0) ? model[8'h10] : model[8'h20];
            qa.push_back(e);
        end
        req = 2'b11;
        seen = 0; grants = 0; pg = '0;
        for (int n = 0; n < 40 && seen < 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_onehot", $onehot0(gnt), 1);
            if (gnt != 0 && pg == 0) grants++;
            pg = gnt;
            if (rdy) seen++;
        end
        req = '0;
        check("rr_rdy_count", seen, 4);
        check("rr_gnt_count", grants, 4);
        @(posedge clk);
        @(negedge clk);

        run(0, 2'b01, 8'h30, 8'h00, 1'b0);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
